// File: rtl/tartaruga_pkg.sv
// Shared tartaruga pipeline types: writeback request, load sizes, writeback FSM states.
// Also holds the lane-extension helper used by the load aligner.
package tartaruga_pkg;

    localparam int CNT_W = 64;

    typedef logic [31:0] bus32_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [1:0] {
        LS_B = 2'd0,
        LS_H = 2'd1,
        LS_W = 2'd2
    } load_size_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } wb_state_t;

    typedef struct packed {
        reg_addr_t  rd;
        logic       we;
        logic       is_load;
        load_size_t size;
        logic       is_unsigned;
        logic [1:0] offset;
        bus32_t     result;
    } wb_req_t;

    // Sign- or zero-extend a byte (is_half=0, lane[7:0]) or a halfword lane to a full word.
    function automatic bus32_t extend_lane(input logic [15:0] lane,
                                           input logic        is_half,
                                           input logic        is_unsigned);
        bus32_t ext;
        if (is_half) begin
            ext = {{16{lane[15] & ~is_unsigned}}, lane};
        end else begin
            ext = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
        end
        return ext;
    endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load aligner: extracts the addressed byte/half from a word-aligned read,
// extends it, and flags accesses that are not naturally aligned.
module load_align
    import tartaruga_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  load_size_t  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [15:0] lane_s;

    // Select the byte or halfword lane addressed by the offset
    always_comb begin
        lane_s = 16'd0;
        case (size_i)
            LS_B: begin
                case (offset_i)
                    2'd0:    lane_s = {8'd0, rdata_i[7:0]};
                    2'd1:    lane_s = {8'd0, rdata_i[15:8]};
                    2'd2:    lane_s = {8'd0, rdata_i[23:16]};
                    default: lane_s = {8'd0, rdata_i[31:24]};
                endcase
            end
            LS_H:    lane_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
            default: lane_s = 16'd0;
        endcase
    end

    // Extend the lane; an unencoded size is treated as misaligned so it gets dropped
    always_comb begin
        data_o     = 32'd0;
        misalign_o = 1'b0;
        case (size_i)
            LS_B: begin
                data_o     = extend_lane(lane_s, 1'b0, unsigned_i);
                misalign_o = 1'b0;
            end
            LS_H: begin
                data_o     = extend_lane(lane_s, 1'b1, unsigned_i);
                misalign_o = offset_i[0];
            end
            LS_W: begin
                data_o     = rdata_i;
                misalign_o = (offset_i != 2'd0);
            end
            default: begin
                data_o     = 32'd0;
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: waits for load responses, aligns load data and drives the
// register-file write port one cycle later; keeps retire and load-stall counters.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = tartaruga_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0]       rd_addr_i,
    input  logic             rd_we_i,
    input  logic [XLEN-1:0]  result_i,
    input  logic             is_load_i,
    input  logic [1:0]       ld_size_i,
    input  logic             ld_unsigned_i,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic [4:0]       addr_rd_o,
    output logic [XLEN-1:0]  data_rd_o,
    output logic             write_enable_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [CNT_W-1:0] ld_stall_o
);
    import tartaruga_pkg::*;

    wb_state_t        state_q, state_d;
    wb_req_t          req_s;
    logic             accept_s;
    logic             in_wait_s;

    logic [1:0]       al_off_s;
    load_size_t       al_size_s;
    logic             al_uns_s;
    logic [31:0]      al_data_s;
    logic             al_mis_s;

    reg_addr_t        pend_rd_q, pend_rd_d;
    load_size_t       pend_size_q, pend_size_d;
    logic             pend_uns_q, pend_uns_d;
    logic [1:0]       pend_off_q, pend_off_d;

    logic             we_q, we_d;
    reg_addr_t        addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign req_s.rd          = rd_addr_i;
    assign req_s.we          = rd_we_i;
    assign req_s.is_load     = is_load_i;
    assign req_s.size        = load_size_t'(ld_size_i);
    assign req_s.is_unsigned = ld_unsigned_i;
    assign req_s.offset      = result_i[1:0];
    assign req_s.result      = result_i;

    // ready depends on state only, so there is no combinational path from valid_i
    assign ready_o   = (state_q != S_WAIT);
    assign accept_s  = valid_i && ready_o;
    assign in_wait_s = (state_q == S_WAIT);

    // One aligner serves both jobs: misalign check at acceptance, data extraction in S_WAIT
    assign al_off_s  = in_wait_s ? pend_off_q  : req_s.offset;
    assign al_size_s = in_wait_s ? pend_size_q : req_s.size;
    assign al_uns_s  = in_wait_s ? pend_uns_q  : req_s.is_unsigned;

    load_align u_load_align (
        .rdata_i    (dmem_rdata_i),
        .offset_i   (al_off_s),
        .size_i     (al_size_s),
        .unsigned_i (al_uns_s),
        .data_o     (al_data_s),
        .misalign_o (al_mis_s)
    );

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a misaligned load is dropped without ever waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WRITE: begin
                if (accept_s && req_s.is_load && !al_mis_s) begin
                    state_d = S_WAIT;
                end else if (accept_s) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output, pending-load and counter next values
    always_comb begin
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        mis_d       = 1'b0;
        instret_d   = instret_q;
        stall_d     = stall_q;
        pend_rd_d   = pend_rd_q;
        pend_size_d = pend_size_q;
        pend_uns_d  = pend_uns_q;
        pend_off_d  = pend_off_q;
        case (state_q)
            S_IDLE, S_WRITE: begin
                if (accept_s && req_s.is_load) begin
                    if (al_mis_s) begin
                        mis_d     = 1'b1;
                        instret_d = instret_q + CNT_W'(1'b1);
                    end else begin
                        pend_rd_d   = req_s.rd;
                        pend_size_d = req_s.size;
                        pend_uns_d  = req_s.is_unsigned;
                        pend_off_d  = req_s.offset;
                    end
                end else if (accept_s) begin
                    we_d      = req_s.we && (req_s.rd != 5'd0);
                    addr_d    = req_s.rd;
                    data_d    = req_s.result;
                    instret_d = instret_q + CNT_W'(1'b1);
                end else begin
                    we_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    we_d      = (pend_rd_q != 5'd0);
                    addr_d    = pend_rd_q;
                    data_d    = al_data_s;
                    instret_d = instret_q + CNT_W'(1'b1);
                end else begin
                    stall_d = stall_q + CNT_W'(1'b1);
                end
            end
            default: we_d = 1'b0;
        endcase
    end

    // Output, pending-load and counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q        <= 1'b0;
            addr_q      <= 5'd0;
            data_q      <= '0;
            mis_q       <= 1'b0;
            instret_q   <= '0;
            stall_q     <= '0;
            pend_rd_q   <= 5'd0;
            pend_size_q <= LS_B;
            pend_uns_q  <= 1'b0;
            pend_off_q  <= 2'd0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mis_q       <= mis_d;
            instret_q   <= instret_d;
            stall_q     <= stall_d;
            pend_rd_q   <= pend_rd_d;
            pend_size_q <= pend_size_d;
            pend_uns_q  <= pend_uns_d;
            pend_off_q  <= pend_off_d;
        end
    end

    assign write_enable_o = we_q;
    assign addr_rd_o      = addr_q;
    assign data_rd_o      = data_q;
    assign misalign_o     = mis_q;
    assign instret_o      = instret_q;
    assign ld_stall_o     = stall_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected writes/drops go into a scoreboard queue
// when stimulus is driven and are popped whenever the stage issues a write or drop.
module tb_writeback_stage;
    import tartaruga_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        rd_we_i = 1'b0;
    logic [31:0] result_i = 32'd0;
    logic        is_load_i = 1'b0;
    logic [1:0]  ld_size_i = 2'd0;
    logic        ld_unsigned_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'd0;
    logic [4:0]  addr_rd_o;
    logic [31:0] data_rd_o;
    logic        write_enable_o;
    logic        misalign_o;
    logic [63:0] instret_o;
    logic [63:0] ld_stall_o;

    always #5 clk_i = ~clk_i;

    writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .rd_addr_i      (rd_addr_i),
        .rd_we_i        (rd_we_i),
        .result_i       (result_i),
        .is_load_i      (is_load_i),
        .ld_size_i      (ld_size_i),
        .ld_unsigned_i  (ld_unsigned_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .addr_rd_o      (addr_rd_o),
        .data_rd_o      (data_rd_o),
        .write_enable_o (write_enable_o),
        .misalign_o     (misalign_o),
        .instret_o      (instret_o),
        .ld_stall_o     (ld_stall_o)
    );

    typedef struct {
        logic        mis;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_instret = 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wb(input logic mis, input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        e.mis  = mis;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
        exp_instret = exp_instret + 64'd1;
    endtask

    // Advance one clock and check any write/drop the stage issued against the scoreboard
    task automatic step();
        exp_t e;
        @(posedge clk_i);
        #1;
        if (write_enable_o || misalign_o) begin
            chk("wb_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_we", 64'(write_enable_o), 64'(!e.mis));
                chk("wb_misalign", 64'(misalign_o), 64'(e.mis));
                if (!e.mis) begin
                    chk("wb_addr", 64'(addr_rd_o), 64'(e.addr));
                    chk("wb_data", 64'(data_rd_o), 64'(e.data));
                end
            end
        end
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
        valid_i       = 1'b1;
        rd_addr_i     = rd;
        rd_we_i       = we;
        result_i      = res;
        is_load_i     = 1'b0;
        ld_size_i     = 2'd0;
        ld_unsigned_i = 1'b0;
        if (we && rd != 5'd0) begin
            push_wb(1'b0, rd, res);
        end else begin
            exp_instret = exp_instret + 64'd1;
        end
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] addr,
                              input logic [1:0] size, input logic uns);
        valid_i       = 1'b1;
        rd_addr_i     = rd;
        rd_we_i       = 1'b1;
        result_i      = addr;
        is_load_i     = 1'b1;
        ld_size_i     = size;
        ld_unsigned_i = uns;
    endtask

    // Load that gets its response in the first wait cycle
    task automatic quick_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] rdata, input logic [31:0] exp_data);
        drive_load(rd, addr, size, uns);
        step();
        valid_i = 1'b0;
        chk("ql_ready_wait", 64'(ready_o), 64'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        push_wb(1'b0, rd, exp_data);
        step();
        dmem_rvalid_i = 1'b0;
        chk("ql_ready_after", 64'(ready_o), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_we", 64'(write_enable_o), 64'd0);
        chk("rst_addr", 64'(addr_rd_o), 64'd0);
        chk("rst_data", 64'(data_rd_o), 64'd0);
        chk("rst_mis", 64'(misalign_o), 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_stall", ld_stall_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        rstn_i = 1'b1;
        step();

        // 1: single ALU write
        drive_alu(5'd5, 1'b1, 32'hDEADBEEF);
        step();
        valid_i = 1'b0;
        chk("t1_instret", instret_o, exp_instret);
        chk("t1_ready", 64'(ready_o), 64'd1);
        step();
        chk("t1_we_drop", 64'(write_enable_o), 64'd0);

        // 2: LB at 0x103, response three cycles after acceptance
        drive_load(5'd7, 32'h0000_0103, LS_B, 1'b0);
        step();
        valid_i      = 1'b0;
        dmem_rdata_i = 32'h1234_5678;
        chk("t2_ready_w0", 64'(ready_o), 64'd0);
        step();
        chk("t2_ready_w1", 64'(ready_o), 64'd0);
        step();
        chk("t2_ready_w2", 64'(ready_o), 64'd0);
        chk("t2_stall_wait", ld_stall_o, 64'd2);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80FF_0000;
        push_wb(1'b0, 5'd7, 32'hFFFF_FF80);
        step();
        dmem_rvalid_i = 1'b0;
        chk("t2_stall", ld_stall_o, 64'd2);
        chk("t2_ready", 64'(ready_o), 64'd1);
        chk("t2_instret", instret_o, exp_instret);

        // 3: alignment/extension variants, then misaligned LW
        quick_load(5'd9,  32'h0000_1002, LS_H, 1'b1, 32'hBEEF_1234, 32'h0000_BEEF);
        quick_load(5'd11, 32'h0000_2001, LS_B, 1'b1, 32'h0000_8000, 32'h0000_0080);
        quick_load(5'd13, 32'h0000_2000, LS_H, 1'b0, 32'h0000_8001, 32'hFFFF_8001);
        quick_load(5'd14, 32'h0000_4000, LS_W, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        drive_load(5'd10, 32'h0000_3001, LS_W, 1'b0);
        push_wb(1'b1, 5'd0, 32'd0);
        step();
        valid_i = 1'b0;
        chk("t3_mis_ready", 64'(ready_o), 64'd1);
        chk("t3_instret", instret_o, exp_instret);
        step();
        chk("t3_mis_pulse_end", 64'(misalign_o), 64'd0);
        chk("t3_stall", ld_stall_o, 64'd2);

        // 4: back-to-back ALU ops with valid held
        drive_alu(5'd1, 1'b1, 32'h0000_0011);
        step();
        chk("t4_ready_a", 64'(ready_o), 64'd1);
        drive_alu(5'd2, 1'b1, 32'h0000_0022);
        step();
        chk("t4_ready_b", 64'(ready_o), 64'd1);
        chk("t4_we_b", 64'(write_enable_o), 64'd1);
        drive_alu(5'd3, 1'b1, 32'h0000_0033);
        step();
        chk("t4_ready_c", 64'(ready_o), 64'd1);
        chk("t4_we_c", 64'(write_enable_o), 64'd1);
        valid_i = 1'b0;
        step();
        chk("t4_we_end", 64'(write_enable_o), 64'd0);
        chk("t4_instret", instret_o, exp_instret);

        // 5: rd=x0 and rd_we=0 never write; stray response in idle is ignored
        drive_alu(5'd0, 1'b1, 32'h0000_0055);
        step();
        valid_i = 1'b0;
        chk("t5_x0_we", 64'(write_enable_o), 64'd0);
        chk("t5_x0_instret", instret_o, exp_instret);
        drive_alu(5'd4, 1'b0, 32'h0000_0044);
        step();
        valid_i = 1'b0;
        chk("t5_nowe_we", 64'(write_enable_o), 64'd0);
        chk("t5_nowe_instret", instret_o, exp_instret);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        step();
        step();
        dmem_rvalid_i = 1'b0;
        chk("t5_stray_we", 64'(write_enable_o), 64'd0);
        chk("t5_stray_ready", 64'(ready_o), 64'd1);
        chk("t5_stray_stall", ld_stall_o, 64'd2);
        chk("t5_stray_instret", instret_o, exp_instret);

        // 6: reset during S_WAIT discards the load
        drive_load(5'd12, 32'h0000_5000, LS_W, 1'b0);
        step();
        valid_i = 1'b0;
        chk("t6_ready_wait", 64'(ready_o), 64'd0);
        #2;
        rstn_i = 1'b0;
        #1;
        exp_instret = 64'd0;
        chk("t6_rst_we", 64'(write_enable_o), 64'd0);
        chk("t6_rst_addr", 64'(addr_rd_o), 64'd0);
        chk("t6_rst_data", 64'(data_rd_o), 64'd0);
        chk("t6_rst_mis", 64'(misalign_o), 64'd0);
        chk("t6_rst_instret", instret_o, 64'd0);
        chk("t6_rst_stall", ld_stall_o, 64'd0);
        chk("t6_rst_ready", 64'(ready_o), 64'd1);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        step();
        rstn_i = 1'b1;
        step();
        step();
        dmem_rvalid_i = 1'b0;
        chk("t6_post_we", 64'(write_enable_o), 64'd0);
        chk("t6_post_instret", instret_o, exp_instret);
        chk("t6_post_stall", ld_stall_o, 64'd0);
        chk("t6_post_ready", 64'(ready_o), 64'd1);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
